fp_cvt_32_to_i32: RTL

Converts an IEEE 754 binary32 value to a 32-bit signed or unsigned integer, using the same rounding-mode encoding as the integer-to-float converter. It is the float-to-integer half of the FCVT pair in the FPU execute path. The block is a 3-stage pipeline with a clock enable and valid tagging, and reports IEEE invalid and inexact flags.

---
 rtl/fp_cvt_32_to_i32.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_cvt_32_to_i32.sv
// Binary32 to 32-bit signed/unsigned integer converter.
// Three pipeline stages: unpack, align, round/saturate. A clock enable freezes
// every stage together, and a valid bit travels alongside the data.
module fp_cvt_32_to_i32 #(
   parameter int unsigned FPWID = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             vld_i,
   input  logic             op,
   input  logic [2:0]       rm,
   input  logic [FPWID-1:0] i,
   output logic [FPWID-1:0] o,
   output logic             vld_o,
   output logic             inexact,
   output logic             invalid
);

   // Rounding-mode encoding shared with the integer-to-float converter.
   localparam logic [2:0] RmRtz  = 3'd1;
   localparam logic [2:0] RmPinf = 3'd2;
   localparam logic [2:0] RmNinf = 3'd3;
   localparam logic [2:0] RmAway = 3'd4;

   // ---------------------------------------------------------------------
   // Stage 1: unpack and classify
   // ---------------------------------------------------------------------
   logic              s1_vld_q;
   logic              s1_op_q;
   logic [2:0]        s1_rm_q;
   logic              s1_sign_q;
   logic signed [9:0] s1_e_q;
   logic [23:0]       s1_sig_q;
   logic              s1_nan_q;
   logic              s1_inf_q;
   logic              s1_zero_q;

   logic              s1_sign_d;
   logic signed [9:0] s1_e_d;
   logic [23:0]       s1_sig_d;
   logic              s1_nan_d;
   logic              s1_inf_d;
   logic              s1_zero_d;

   // Split the operand into fields and classify it.
   always_comb begin
      s1_sign_d = i[31];
      s1_e_d    = $signed({2'b00, i[30:23]}) - 10'sd127;
      s1_sig_d  = {(i[30:23] != 8'd0), i[22:0]};
      s1_nan_d  = (i[30:23] == 8'hFF) && (i[22:0] != 23'd0);
      s1_inf_d  = (i[30:23] == 8'hFF) && (i[22:0] == 23'd0);
      s1_zero_d = (i[30:0] == 31'd0);
   end

   // Stage 1 register; op and rm ride along with the operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_op_q   <= 1'b0;
         s1_rm_q   <= 3'd0;
         s1_sign_q <= 1'b0;
         s1_e_q    <= '0;
         s1_sig_q  <= '0;
         s1_nan_q  <= 1'b0;
         s1_inf_q  <= 1'b0;
         s1_zero_q <= 1'b0;
      end else if (ce) begin
         s1_vld_q  <= vld_i;
         s1_op_q   <= op;
         s1_rm_q   <= rm;
         s1_sign_q <= s1_sign_d;
         s1_e_q    <= s1_e_d;
         s1_sig_q  <= s1_sig_d;
         s1_nan_q  <= s1_nan_d;
         s1_inf_q  <= s1_inf_d;
         s1_zero_q <= s1_zero_d;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: align significand to the integer point
   // ---------------------------------------------------------------------
   logic        s2_vld_q;
   logic        s2_op_q;
   logic [2:0]  s2_rm_q;
   logic        s2_sign_q;
   logic        s2_nan_q;
   logic        s2_inf_q;
   logic [32:0] s2_mag_q;
   logic        s2_ovf_q;
   logic        s2_g_q;
   logic        s2_r_q;
   logic        s2_s_q;

   logic [32:0] s2_mag_d;
   logic        s2_ovf_d;
   logic        s2_g_d;
   logic        s2_r_d;
   logic        s2_s_d;
   logic [3:0]  lsh;
   logic [4:0]  rsh;
   logic [47:0] rshifted;

   // Left shift for large exponents, right shift with guard/round/sticky
   // extraction for small ones. Anything shifted past bit 32 is overflow.
   always_comb begin
      s2_mag_d = '0;
      s2_ovf_d = 1'b0;
      s2_g_d   = 1'b0;
      s2_r_d   = 1'b0;
      s2_s_d   = 1'b0;
      lsh      = '0;
      rsh      = '0;
      rshifted = '0;
      if (s1_e_q >= 10'sd23) begin
         if (s1_e_q > 10'sd32) begin
            s2_ovf_d = 1'b1;
         end else begin
            lsh      = 4'(s1_e_q - 10'sd23);
            s2_mag_d = {9'd0, s1_sig_q} << lsh;
         end
      end else if (s1_e_q >= 10'sd0) begin
         // Shift amount is 1..23; the low 24 bits catch the dropped bits.
         rsh      = 5'(10'sd23 - s1_e_q);
         rshifted = {s1_sig_q, 24'd0} >> rsh;
         s2_mag_d = {9'd0, rshifted[47:24]};
         s2_g_d   = rshifted[24];
         s2_r_d   = rshifted[23];
         s2_s_d   = |rshifted[22:0];
      end else if (s1_e_q == -10'sd1) begin
         // Value in [0.5, 1): the hidden bit is the round bit.
         s2_r_d = 1'b1;
         s2_s_d = |s1_sig_q[22:0];
      end else begin
         // Below one half, including denormals.
         s2_s_d = !s1_zero_q;
      end
   end

   // Stage 2 register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld_q  <= 1'b0;
         s2_op_q   <= 1'b0;
         s2_rm_q   <= 3'd0;
         s2_sign_q <= 1'b0;
         s2_nan_q  <= 1'b0;
         s2_inf_q  <= 1'b0;
         s2_mag_q  <= '0;
         s2_ovf_q  <= 1'b0;
         s2_g_q    <= 1'b0;
         s2_r_q    <= 1'b0;
         s2_s_q    <= 1'b0;
      end else if (ce) begin
         s2_vld_q  <= s1_vld_q;
         s2_op_q   <= s1_op_q;
         s2_rm_q   <= s1_rm_q;
         s2_sign_q <= s1_sign_q;
         s2_nan_q  <= s1_nan_q;
         s2_inf_q  <= s1_inf_q;
         s2_mag_q  <= s2_mag_d;
         s2_ovf_q  <= s2_ovf_d;
         s2_g_q    <= s2_g_d;
         s2_r_q    <= s2_r_d;
         s2_s_q    <= s2_s_d;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 3: round, range check, saturate
   // ---------------------------------------------------------------------
   logic        inc;
   logic [32:0] m;
   logic        legal_s;
   logic        legal_u;
   logic        legal;
   logic [31:0] neg;
   logic [31:0] sat;
   logic [31:0] o_d;
   logic        inexact_d;
   logic        invalid_d;

   // Rounding increment decision; encodings 5..7 fall back to RNE.
   always_comb begin
      inc = 1'b0;
      case (s2_rm_q)
         RmRtz:   inc = 1'b0;
         RmPinf:  inc = (s2_r_q | s2_s_q) & !s2_sign_q;
         RmNinf:  inc = (s2_r_q | s2_s_q) & s2_sign_q;
         RmAway:  inc = s2_r_q | s2_s_q;
         default: inc = s2_r_q & (s2_g_q | s2_s_q);
      endcase
   end

   // Result selection: NaN, saturation or the rounded (possibly negated) value.
   always_comb begin
      m       = s2_mag_q + {32'd0, inc};
      legal_s = (m <= 33'h0_7FFF_FFFF) || (s2_sign_q && (m == 33'h0_8000_0000));
      legal_u = (!s2_sign_q && (m <= 33'h0_FFFF_FFFF)) || (m == 33'd0);
      legal   = !s2_ovf_q && (s2_op_q ? legal_s : legal_u);
      neg     = 32'd0 - m[31:0];
      if (s2_op_q) begin
         sat = s2_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         sat = s2_sign_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
      end
      o_d       = '0;
      inexact_d = 1'b0;
      invalid_d = 1'b0;
      if (s2_nan_q) begin
         o_d       = s2_op_q ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
         invalid_d = 1'b1;
      end else if (s2_inf_q || !legal) begin
         o_d       = sat;
         invalid_d = 1'b1;
      end else begin
         o_d       = s2_sign_q ? neg : m[31:0];
         inexact_d = s2_r_q | s2_s_q;
      end
   end

   // Output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_o   <= 1'b0;
         o       <= '0;
         inexact <= 1'b0;
         invalid <= 1'b0;
      end else if (ce) begin
         vld_o   <= s2_vld_q;
         o       <= o_d;
         inexact <= inexact_d;
         invalid <= invalid_d;
      end
   end

endmodule
